mux_nway_reg: RTL



---
 rtl/mux_pkg.sv | 11 +
 rtl/mux_nway_reg_rr_pick.sv | 24 ++
 rtl/mux_nway_reg.sv | 63 ++++++
 3 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared default sizes and ceil-log2 helper for the registered channel mux
package mux_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int NCH_DEF = 4;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/mux_nway_reg_rr_pick.sv
// rr_pick: rotating priority picker, first valid channel at or above ptr (mod NCH)
module rr_pick
  import mux_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int SELW = clog2(NCH)
) (
  input  logic [NCH-1:0]  valid,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] idx,
  output logic            found
);
  // scan offsets from farthest to nearest so the nearest valid channel wins
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (valid[(int'(ptr) + i) % NCH]) begin
        idx = SELW'((int'(ptr) + i) % NCH);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_nway_reg.sv
// mux_nway_reg: N-way W-bit channel mux with one valid/ready output register; MUX_NWAY_ROUND_ROBIN_EN selects round-robin arbitration instead of sel
module mux_nway_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NCH = NCH_DEF,
  parameter int SELW = clog2(NCH)
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          xfer_cnt
);
  logic            load_ok;
  logic            c_ok;
  logic            xfer;
  logic [SELW-1:0] c;
  assign load_ok = !out_valid || out_ready;
`ifdef MUX_NWAY_ROUND_ROBIN_EN
  logic [SELW-1:0] rr_ptr;
  logic            unused_sel;
  assign unused_sel = ^sel;
  rr_pick #(.NCH(NCH), .SELW(SELW)) u_pick (
    .valid(in_valid),
    .ptr  (rr_ptr),
    .idx  (c),
    .found(c_ok)
  );
  // pointer moves past the served channel only on a transfer, so stalls hold it
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) rr_ptr <= '0;
    else if (xfer) rr_ptr <= (int'(c) == NCH - 1) ? '0 : c + 1'b1;
  end
`else
  assign c = sel;
  assign c_ok = int'(sel) < NCH;
`endif
  assign in_ready = (load_ok && c_ok) ? {{(NCH-1){1'b0}}, 1'b1} << c : '0;
  assign xfer = |(in_ready & in_valid);
  // output stage: load on transfer, drain when accepted, hold while stalled
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_data <= '0;
      out_ch <= '0;
      out_valid <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      if (xfer) begin
        out_data <= in_data[c*WIDTH +: WIDTH];
        out_ch <= c;
        xfer_cnt <= xfer_cnt + 16'd1;
      end
      out_valid <= xfer ? 1'b1 : out_ready ? 1'b0 : out_valid;
    end
  end
endmodule
